// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache refill and D-cache refill/write for the
// single shared memory port, with a per-transaction watchdog.
//
//   state | meaning
//   IDLE  | waiting for a request, arbitrates and latches the winner
//   IC_RD | I-side line read outstanding at memory
//   DC_RD | D-side line read outstanding at memory
//   DC_WR | D-side write outstanding at memory
//   RESP  | one-cycle done pulse to the granted requester
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ic_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_ic_read_address,
    output logic                        o_ic_read_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_ic_cache_line,
    input  logic                        i_dc_read_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_read_address,
    output logic                        o_dc_read_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_dc_cache_line,
    input  logic                        i_dc_write_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_write_address,
    input  logic [DATA_WIDTH-1:0]       i_dc_write_data,
    input  logic [7:0]                  i_dc_write_strobe,
    output logic                        o_dc_write_done,
    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done,
    output logic                        o_timeout
);

    localparam int LOFF = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int CW   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, RESP} state_t;

    state_t                state, state_nxt, kind_r;
    logic                  last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [7:0]            strb_r;
    logic [CW-1:0]         wdog_cnt;

    logic d_pend, grant_i, grant_d, busy_rd, busy, xact_done, tmo_hit;

    assign d_pend    = i_dc_write_req | i_dc_read_req;
    assign grant_i   = i_ic_read_req & (~d_pend | last_grant_d);
    assign grant_d   = d_pend & ~grant_i;
    assign busy_rd   = (state == IC_RD) || (state == DC_RD);
    assign busy      = busy_rd || (state == DC_WR);
    assign xact_done = (busy_rd & i_mem_read_done) | ((state == DC_WR) & i_mem_write_done);
    // Watchdog counts down from the limit; a done in the terminal cycle still wins.
    assign tmo_hit   = busy & (wdog_cnt == '0) & ~xact_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_nxt = IC_RD;
                else if (grant_d) state_nxt = i_dc_write_req ? DC_WR : DC_RD;
            end
            IC_RD, DC_RD, DC_WR: begin
                if (xact_done || tmo_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_d    <= 1'b1;
            kind_r          <= IDLE;
            addr_r          <= '0;
            data_r          <= '0;
            strb_r          <= '0;
            wdog_cnt        <= '0;
            o_timeout       <= 1'b0;
            o_ic_cache_line <= '0;
            o_dc_cache_line <= '0;
        end else begin
            if (state == IDLE && (grant_i || grant_d)) begin
                last_grant_d <= grant_d;
                kind_r       <= state_nxt;
                wdog_cnt     <= CW'(TIMEOUT_CYCLES - 1);
                if (grant_i) begin
                    addr_r <= i_ic_read_address;
                end else if (i_dc_write_req) begin
                    addr_r <= i_dc_write_address;
                    data_r <= i_dc_write_data;
                    strb_r <= i_dc_write_strobe;
                end else begin
                    addr_r <= i_dc_read_address;
                end
            end else if (busy && wdog_cnt != '0) begin
                wdog_cnt <= wdog_cnt - CW'(1);
            end
            if (tmo_hit) o_timeout <= 1'b1;
            if (state == IC_RD && (i_mem_read_done || tmo_hit))
                o_ic_cache_line <= tmo_hit ? '0 : i_cache_line;
            if (state == DC_RD && (i_mem_read_done || tmo_hit))
                o_dc_cache_line <= tmo_hit ? '0 : i_cache_line;
        end
    end

    always_comb begin
        o_mem_read_req    = busy_rd;
        o_mem_write_valid = (state == DC_WR);
        o_ic_read_done    = 1'b0;
        o_dc_read_done    = 1'b0;
        o_dc_write_done   = 1'b0;
        if (state == RESP) begin
            case (kind_r)
                IC_RD:   o_ic_read_done  = 1'b1;
                DC_RD:   o_dc_read_done  = 1'b1;
                DC_WR:   o_dc_write_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_mem_read_address  = {addr_r[ADDR_WIDTH-1:LOFF], {LOFF{1'b0}}};
    assign o_mem_write_address = addr_r;
    assign o_mem_write_data    = data_r;
    assign o_write_strobe      = strb_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, write-before-read,
// watchdog boundary and timeout, async reset and stray done pulses.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_read_req;
    logic [63:0]  ic_read_address;
    logic         ic_read_done;
    logic [255:0] ic_cache_line;
    logic         dc_read_req;
    logic [63:0]  dc_read_address;
    logic         dc_read_done;
    logic [255:0] dc_cache_line;
    logic         dc_write_req;
    logic [63:0]  dc_write_address;
    logic [63:0]  dc_write_data;
    logic [7:0]   dc_write_strobe;
    logic         dc_write_done;
    logic         mem_read_req;
    logic [63:0]  mem_read_address;
    logic         mem_read_done;
    logic [255:0] cache_line;
    logic         mem_write_valid;
    logic [63:0]  mem_write_address;
    logic [63:0]  mem_write_data;
    logic [7:0]   write_strobe;
    logic         mem_write_done;
    logic         timeout;

    int passed = 0;
    int total  = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_1  = {4{64'h1111_2222_3333_4444}};
    localparam logic [255:0] LINE_2  = {4{64'h5555_6666_7777_8888}};
    localparam logic [255:0] LINE_3  = {4{64'h9999_AAAA_BBBB_CCCC}};
    localparam logic [255:0] LINE_4  = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] LINE_5  = {4{64'hFEDC_BA98_7654_3210}};
    localparam logic [255:0] LINE_6  = {4{64'h0F0F_0F0F_F0F0_F0F0}};

    mem_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .CACHE_LINE_WIDTH(256), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ic_read_req(ic_read_req), .i_ic_read_address(ic_read_address),
        .o_ic_read_done(ic_read_done), .o_ic_cache_line(ic_cache_line),
        .i_dc_read_req(dc_read_req), .i_dc_read_address(dc_read_address),
        .o_dc_read_done(dc_read_done), .o_dc_cache_line(dc_cache_line),
        .i_dc_write_req(dc_write_req), .i_dc_write_address(dc_write_address),
        .i_dc_write_data(dc_write_data), .i_dc_write_strobe(dc_write_strobe),
        .o_dc_write_done(dc_write_done),
        .o_mem_read_req(mem_read_req), .o_mem_read_address(mem_read_address),
        .i_mem_read_done(mem_read_done), .i_cache_line(cache_line),
        .o_mem_write_valid(mem_write_valid), .o_mem_write_address(mem_write_address),
        .o_mem_write_data(mem_write_data), .o_write_strobe(write_strobe),
        .i_mem_write_done(mem_write_done), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {ic_read_done, dc_read_done, dc_write_done,
                            mem_read_req, mem_write_valid, timeout}, 0);
        chk({tag, "_ic_line"}, ic_cache_line, 0);
        chk({tag, "_dc_line"}, dc_cache_line, 0);
        chk({tag, "_addr"}, {mem_read_address, mem_write_address, mem_write_data, write_strobe}, 0);
    endtask

    // Waits for the read grant, answers done in the first busy cycle, checks the response.
    task automatic serve_read(input bit side_i, input logic [63:0] exp_addr,
                              input logic [255:0] line, input string tag);
        for (int i = 0; i < 20 && mem_read_req !== 1'b1; i++) @(negedge clk);
        chk({tag, "_req"}, mem_read_req, 1);
        chk({tag, "_addr"}, mem_read_address, exp_addr);
        mem_read_done = 1'b1;
        cache_line    = line;
        @(negedge clk);
        chk({tag, "_done"}, side_i ? {ic_read_done, dc_read_done} : {dc_read_done, ic_read_done}, 2'b10);
        chk({tag, "_line"}, side_i ? ic_cache_line : dc_cache_line, line);
        mem_read_done = 1'b0;
        if (side_i) ic_read_req = 1'b0;
        else        dc_read_req = 1'b0;
        @(negedge clk);
        chk({tag, "_after"}, {ic_read_done, dc_read_done, dc_write_done, mem_read_req}, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        ic_read_req = 0; ic_read_address = 0;
        dc_read_req = 0; dc_read_address = 0;
        dc_write_req = 0; dc_write_address = 0; dc_write_data = 0; dc_write_strobe = 0;
        mem_read_done = 0; cache_line = 0; mem_write_done = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // I read 0x1234, memory answers in the 4th busy cycle
        ic_read_req = 1'b1; ic_read_address = 64'h1234;
        @(negedge clk);
        chk("t1_req", mem_read_req, 1);
        chk("t1_addr", mem_read_address, 64'h1220);
        repeat (2) @(negedge clk);
        chk("t1_wait", {mem_read_req, ic_read_done}, 2'b10);
        @(negedge clk);
        mem_read_done = 1'b1; cache_line = LINE_A5;
        @(negedge clk);
        chk("t1_done", {ic_read_done, dc_read_done, mem_read_req}, 3'b100);
        chk("t1_line", ic_cache_line, LINE_A5);
        mem_read_done = 1'b0; ic_read_req = 1'b0;
        @(negedge clk);
        chk("t1_single_pulse", {ic_read_done, mem_read_req}, 0);

        // Contention after reset: I, then D; then I alone; then D wins the next pair
        pulse_reset();
        ic_read_req = 1'b1; ic_read_address = 64'h100;
        dc_read_req = 1'b1; dc_read_address = 64'h2040;
        serve_read(1'b1, 64'h100, LINE_1, "pair1_i");
        serve_read(1'b0, 64'h2040, LINE_2, "pair1_d");
        chk("pair1_ic_hold", ic_cache_line, LINE_1);
        ic_read_req = 1'b1; ic_read_address = 64'h19F;
        serve_read(1'b1, 64'h180, LINE_3, "solo_i");
        ic_read_req = 1'b1; ic_read_address = 64'h1C0;
        dc_read_req = 1'b1; dc_read_address = 64'h2080;
        serve_read(1'b0, 64'h2080, LINE_4, "pair2_d");
        serve_read(1'b1, 64'h1C0, LINE_5, "pair2_i");
        chk("pair2_dc_hold", dc_cache_line, LINE_4);

        // D write and D read together: write goes first
        dc_write_req = 1'b1; dc_write_address = 64'h40;
        dc_write_data = 64'hDEADBEEF; dc_write_strobe = 8'h0F;
        dc_read_req = 1'b1; dc_read_address = 64'h80;
        @(negedge clk);
        chk("wr_valid", {mem_write_valid, mem_read_req}, 2'b10);
        chk("wr_fields", {mem_write_address, mem_write_data, write_strobe},
            {64'h40, 64'hDEADBEEF, 8'h0F});
        @(negedge clk);
        mem_write_done = 1'b1;
        @(negedge clk);
        chk("wr_done", {dc_write_done, dc_read_done, mem_read_req}, 3'b100);
        mem_write_done = 1'b0; dc_write_req = 1'b0;
        serve_read(1'b0, 64'h80, LINE_6, "rd_after_wr");

        // Stray done pulses in IDLE are ignored
        mem_write_done = 1'b1; mem_read_done = 1'b1; cache_line = LINE_1;
        @(negedge clk);
        mem_write_done = 1'b0; mem_read_done = 1'b0;
        @(negedge clk);
        chk("idle_stray", {ic_read_done, dc_read_done, dc_write_done,
                           mem_read_req, mem_write_valid}, 0);
        chk("idle_stray_line", dc_cache_line, LINE_6);

        // Done in the last watchdog cycle counts as normal completion
        dc_read_req = 1'b1; dc_read_address = 64'h340;
        @(negedge clk);
        chk("lim_req", mem_read_req, 1);
        repeat (7) @(negedge clk);
        chk("lim_busy", {mem_read_req, dc_read_done}, 2'b10);
        mem_read_done = 1'b1; cache_line = LINE_2;
        @(negedge clk);
        chk("lim_done", {dc_read_done, timeout}, 2'b10);
        chk("lim_line", dc_cache_line, LINE_2);
        mem_read_done = 1'b0; dc_read_req = 1'b0;
        @(negedge clk);

        // Memory never answers: watchdog fires after 8 busy cycles
        dc_read_req = 1'b1; dc_read_address = 64'h380;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1 || k == 8)
                chk($sformatf("tmo_busy_%0d", k), {mem_read_req, dc_read_done, timeout}, 3'b100);
        end
        @(negedge clk);
        chk("tmo_done", {dc_read_done, timeout, mem_read_req}, 3'b110);
        chk("tmo_line", dc_cache_line, 0);
        dc_read_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_sticky", {timeout, dc_read_done}, 2'b10);

        // Async reset two cycles into an I read
        ic_read_req = 1'b1; ic_read_address = 64'h500;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", mem_read_req, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        ic_read_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dc_write_req = 1'b1; dc_write_address = 64'h600;
        dc_write_data = 64'h0BAD_F00D; dc_write_strobe = 8'hF0;
        for (int i = 0; i < 20 && mem_write_valid !== 1'b1; i++) begin
            @(negedge clk);
            chk("rst_no_stale", ic_read_done, 0);
        end
        chk("rst_wr_valid", {mem_write_valid, mem_read_req}, 2'b10);
        chk("rst_wr_addr", mem_write_address, 64'h600);
        mem_write_done = 1'b1;
        @(negedge clk);
        chk("rst_wr_done", {dc_write_done, ic_read_done, timeout}, 3'b100);
        mem_write_done = 1'b0; dc_write_req = 1'b0;
        @(negedge clk);
        chk("rst_end_idle", {dc_write_done, ic_read_done, mem_write_valid}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
